// File: rtl/time_set_ctrl.sv
// Mode/edit controller for the clock's time-field counters: run/freeze, field select, up/down stepping with auto-repeat, blink.
// Latency: every output is registered; a button press sampled on one edge shows on the outputs right after that edge.
// Backpressure: none; the buttons are levels, the ticks are strobes, and the field pulses are one-cycle fire-and-forget.
module time_set_ctrl #(
  parameter int NUM_FIELDS  = 6,
  parameter int HOLD_TICKS  = 5,
  parameter int BLINK_TICKS = 3,
  parameter int TIMEOUT_SEC = 30
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick_1hz,
  input  logic                          tick_fast,
  input  logic                          btn_mode,
  input  logic                          btn_up,
  input  logic                          btn_down,
  output logic                          run_en,
  output logic [$clog2(NUM_FIELDS)-1:0] edit_idx,
  output logic [NUM_FIELDS-1:0]         field_up,
  output logic [NUM_FIELDS-1:0]         field_down,
  output logic                          blink
);

  localparam int IW = $clog2(NUM_FIELDS);
  localparam int RW = $clog2(HOLD_TICKS + 1);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int TW = $clog2(TIMEOUT_SEC + 1);

  localparam logic [IW-1:0] IDX_TOP    = IW'(NUM_FIELDS - 1);
  localparam logic [RW-1:0] HOLD_MAX   = RW'(HOLD_TICKS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_SEC - 1);

  typedef enum logic {S_RUN, S_EDIT} state_t;
  typedef enum logic [1:0] {R_NONE, R_UP, R_DN} rdir_t;

  state_t                state_q, state_d;
  rdir_t                 rdir_q, rdir_d;
  logic                  mode_h_q, up_h_q, dn_h_q;
  logic                  run_en_q, run_en_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_FIELDS-1:0] fup_q, fup_d, fdn_q, fdn_d;
  logic                  blink_q, blink_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [RW-1:0]         rcnt_q, rcnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic mode_p, up_p, dn_p, any_p;
  logic step_up, step_dn, timeout, go_run;

  // Rising-edge detect; history starts at 1 so a button held through reset is not a press.
  assign mode_p = btn_mode & ~mode_h_q;
  assign up_p   = btn_up   & ~up_h_q;
  assign dn_p   = btn_down & ~dn_h_q;
  assign any_p  = mode_p | up_p | dn_p;

  // State register and all output/timer flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      rdir_q   <= R_NONE;
      mode_h_q <= 1'b1;
      up_h_q   <= 1'b1;
      dn_h_q   <= 1'b1;
      run_en_q <= 1'b1;
      idx_q    <= '0;
      fup_q    <= '0;
      fdn_q    <= '0;
      blink_q  <= 1'b0;
      bcnt_q   <= '0;
      rcnt_q   <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      rdir_q   <= rdir_d;
      mode_h_q <= btn_mode;
      up_h_q   <= btn_up;
      dn_h_q   <= btn_down;
      run_en_q <= run_en_d;
      idx_q    <= idx_d;
      fup_q    <= fup_d;
      fdn_q    <= fdn_d;
      blink_q  <= blink_d;
      bcnt_q   <= bcnt_d;
      rcnt_q   <= rcnt_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state: mode navigation, timeout, step/auto-repeat and blink phase.
  always_comb begin
    state_d  = state_q;
    rdir_d   = rdir_q;
    run_en_d = run_en_q;
    idx_d    = idx_q;
    fup_d    = '0;
    fdn_d    = '0;
    blink_d  = blink_q;
    bcnt_d   = bcnt_q;
    rcnt_d   = rcnt_q;
    tmo_d    = tmo_q;
    step_up  = 1'b0;
    step_dn  = 1'b0;
    timeout  = 1'b0;
    go_run   = 1'b0;

    case (state_q)
      S_RUN: begin
        // Up/down are ignored while running; only mode opens the editor at the top field.
        run_en_d = 1'b1;
        idx_d    = '0;
        blink_d  = 1'b0;
        bcnt_d   = '0;
        tmo_d    = '0;
        rdir_d   = R_NONE;
        rcnt_d   = '0;
        if (mode_p) begin
          state_d  = S_EDIT;
          run_en_d = 1'b0;
          idx_d    = IDX_TOP;
          blink_d  = 1'b1;
        end
      end

      default: begin
        run_en_d = 1'b0;
        // Inactivity timer; a press on the final tick keeps the editor open.
        if (any_p) begin
          tmo_d = '0;
        end else if (tick_1hz) begin
          if (tmo_q == TMO_LAST) timeout = 1'b1;
          else                   tmo_d   = tmo_q + 1'b1;
        end

        if (mode_p) begin
          // Mode beats any simultaneous or held up/down: repeat state is dropped.
          rdir_d  = R_NONE;
          rcnt_d  = '0;
          blink_d = 1'b1;
          bcnt_d  = '0;
          if (idx_q == '0) go_run = 1'b1;
          else             idx_d  = idx_q - 1'b1;
        end else if (timeout) begin
          go_run = 1'b1;
        end else begin
          if (btn_up && btn_down) begin
            rdir_d = R_NONE;
            rcnt_d = '0;
          end else if (up_p) begin
            step_up = 1'b1;
            rdir_d  = R_UP;
            rcnt_d  = '0;
          end else if (dn_p) begin
            step_dn = 1'b1;
            rdir_d  = R_DN;
            rcnt_d  = '0;
          end else if ((rdir_q == R_UP && btn_up) || (rdir_q == R_DN && btn_down)) begin
            // Count the hold, then fire once per fast tick.
            if (tick_fast) begin
              if (rcnt_q == HOLD_MAX) begin
                step_up = (rdir_q == R_UP);
                step_dn = (rdir_q == R_DN);
              end else begin
                rcnt_d = rcnt_q + 1'b1;
              end
            end
          end else begin
            rdir_d = R_NONE;
            rcnt_d = '0;
          end

          if (step_up) fup_d = NUM_FIELDS'(1) << idx_q;
          if (step_dn) fdn_d = NUM_FIELDS'(1) << idx_q;

          // A step shows the new value immediately, restarting the blink half-period.
          if (step_up || step_dn) begin
            blink_d = 1'b1;
            bcnt_d  = '0;
          end else if (tick_fast) begin
            if (bcnt_q == BLINK_LAST) begin
              blink_d = ~blink_q;
              bcnt_d  = '0;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end

        if (go_run) begin
          state_d  = S_RUN;
          run_en_d = 1'b1;
          idx_d    = '0;
          blink_d  = 1'b0;
          bcnt_d   = '0;
          tmo_d    = '0;
          rdir_d   = R_NONE;
          rcnt_d   = '0;
          fup_d    = '0;
          fdn_d    = '0;
        end
      end
    endcase
  end

  assign run_en     = run_en_q;
  assign edit_idx   = idx_q;
  assign field_up   = fup_q;
  assign field_down = fdn_q;
  assign blink      = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: one-cycle vector table plus timeout and async-reset sequences.
// Each applied cycle drives inputs just after a rising edge and checks outputs 1 time unit after the next one.
// No backpressure; the bench owns all inputs.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0, tick_fast = 1'b0;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       run_en, blink;
  logic [2:0] edit_idx;
  logic [5:0] field_up, field_down;

  int n_vec = 0;
  int n_bad = 0;

  time_set_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_fast(tick_fast),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .run_en(run_en), .edit_idx(edit_idx), .field_up(field_up),
    .field_down(field_down), .blink(blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       m, u, d, tf, t1;
    logic       er;
    logic [2:0] ei;
    logic [5:0] eu, ed;
    logic       eb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic m, u, d, tf, t1, er, input logic [2:0] ei,
                             input logic [5:0] eu, ed, input logic eb);
    vec_t r;
    r.m = m; r.u = u; r.d = d; r.tf = tf; r.t1 = t1;
    r.er = er; r.ei = ei; r.eu = eu; r.ed = ed; r.eb = eb;
    return r;
  endfunction

  task automatic cyc(input logic m, u, d, tf, t1);
    btn_mode = m; btn_up = u; btn_down = d; tick_fast = tf; tick_1hz = t1;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic er, input logic [2:0] ei,
                       input logic [5:0] eu, ed, input logic eb);
    n_vec++;
    if ({run_en, edit_idx, field_up, field_down, blink} !== {er, ei, eu, ed, eb}) begin
      n_bad++;
      $display("FAIL %s: got run_en=%b idx=%0d up=%b dn=%b blink=%b, want run_en=%b idx=%0d up=%b dn=%b blink=%b",
               nm, run_en, edit_idx, field_up, field_down, blink, er, ei, eu, ed, eb);
    end
  endtask

  initial begin
    // m u d tf t1 | run idx up dn blink
    tbl.push_back(v(0,0,0,0,0, 1,0,6'd0,6'd0,0));
    tbl.push_back(v(1,0,0,0,0, 0,5,6'd0,6'd0,1));   // enter edit at year
    tbl.push_back(v(0,0,0,0,0, 0,5,6'd0,6'd0,1));
    tbl.push_back(v(1,0,0,0,0, 0,4,6'd0,6'd0,1));
    tbl.push_back(v(0,0,0,0,0, 0,4,6'd0,6'd0,1));
    tbl.push_back(v(1,0,0,0,0, 0,3,6'd0,6'd0,1));
    tbl.push_back(v(0,0,0,0,0, 0,3,6'd0,6'd0,1));
    tbl.push_back(v(1,0,0,0,0, 0,2,6'd0,6'd0,1));
    tbl.push_back(v(0,0,0,0,0, 0,2,6'd0,6'd0,1));
    tbl.push_back(v(0,1,0,0,0, 0,2,6'b000100,6'd0,1));   // up tap
    tbl.push_back(v(0,0,0,0,0, 0,2,6'd0,6'd0,1));
    tbl.push_back(v(0,0,1,0,0, 0,2,6'd0,6'b000100,1));   // down tap
    tbl.push_back(v(0,0,0,0,0, 0,2,6'd0,6'd0,1));
    tbl.push_back(v(0,0,0,1,0, 0,2,6'd0,6'd0,1));        // blink phase 1
    tbl.push_back(v(0,0,0,1,0, 0,2,6'd0,6'd0,1));        // blink phase 2
    tbl.push_back(v(0,0,0,1,0, 0,2,6'd0,6'd0,0));        // third tick toggles
    tbl.push_back(v(0,0,0,1,0, 0,2,6'd0,6'd0,0));
    tbl.push_back(v(0,1,1,0,0, 0,2,6'd0,6'd0,0));        // up+down together
    tbl.push_back(v(0,1,1,1,0, 0,2,6'd0,6'd0,0));
    tbl.push_back(v(0,0,0,0,0, 0,2,6'd0,6'd0,0));
    tbl.push_back(v(1,1,0,0,0, 0,1,6'd0,6'd0,1));        // mode+up: mode wins
    tbl.push_back(v(0,1,0,1,0, 0,1,6'd0,6'd0,1));        // held up must not repeat
    tbl.push_back(v(0,1,0,1,0, 0,1,6'd0,6'd0,1));
    tbl.push_back(v(0,0,0,0,0, 0,1,6'd0,6'd0,1));
    tbl.push_back(v(0,1,0,0,0, 0,1,6'b000010,6'd0,1));   // up press
    tbl.push_back(v(0,1,0,1,0, 0,1,6'd0,6'd0,1));        // hold tick 1
    tbl.push_back(v(0,1,0,1,0, 0,1,6'd0,6'd0,1));
    tbl.push_back(v(0,1,0,1,0, 0,1,6'd0,6'd0,0));
    tbl.push_back(v(0,1,0,1,0, 0,1,6'd0,6'd0,0));
    tbl.push_back(v(0,1,0,1,0, 0,1,6'd0,6'd0,0));        // hold tick 5
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(0,1,0,1,0, 0,1,6'b000010,6'd0,1)); // repeat pulses, ticks 6..10
    tbl.push_back(v(0,1,0,0,0, 0,1,6'd0,6'd0,1));
    tbl.push_back(v(0,0,0,1,0, 0,1,6'd0,6'd0,1));        // released: no pulse
    tbl.push_back(v(0,0,0,1,0, 0,1,6'd0,6'd0,1));
    tbl.push_back(v(1,0,0,0,0, 0,0,6'd0,6'd0,1));
    tbl.push_back(v(0,0,0,0,0, 0,0,6'd0,6'd0,1));
    tbl.push_back(v(1,0,0,0,0, 1,0,6'd0,6'd0,0));        // back to run
    tbl.push_back(v(0,1,0,0,0, 1,0,6'd0,6'd0,0));        // up ignored in run
    tbl.push_back(v(0,0,0,0,0, 1,0,6'd0,6'd0,0));

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 1, 0, 6'd0, 6'd0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc(0, 0, 0, (i % 7) == 0, (i % 13) == 0);
      check("idle_run", 1, 0, 6'd0, 6'd0, 0);
    end

    // Vector table
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].m, tbl[i].u, tbl[i].d, tbl[i].tf, tbl[i].t1);
      check($sformatf("vec%0d", i), tbl[i].er, tbl[i].ei, tbl[i].eu, tbl[i].ed, tbl[i].eb);
    end

    // Timeout after 30 idle seconds
    cyc(1, 0, 0, 0, 0);
    check("tmo_enter", 0, 5, 6'd0, 6'd0, 1);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 29; i++) begin
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
    end
    check("tmo_after_29", 0, 5, 6'd0, 6'd0, 1);
    cyc(0, 0, 0, 0, 1);
    check("tmo_at_30", 1, 0, 6'd0, 6'd0, 0);

    // Press coinciding with the final tick keeps edit and restarts the timer
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 29; i++) begin
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
    end
    cyc(0, 1, 0, 0, 1);
    check("tmo_press_wins", 0, 5, 6'b100000, 6'd0, 1);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 29; i++) begin
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
    end
    check("tmo_restart_29", 0, 5, 6'd0, 6'd0, 1);
    cyc(0, 0, 0, 0, 1);
    check("tmo_restart_30", 1, 0, 6'd0, 6'd0, 0);

    // Async reset in the middle of an auto-repeat
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("rst_pre_press", 0, 5, 6'b100000, 6'd0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 1, 0);
    check("rst_pre_repeat", 0, 5, 6'b100000, 6'd0, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_async", 1, 0, 6'd0, 6'd0, 0);
    @(posedge clk);
    #1 check("rst_held", 1, 0, 6'd0, 6'd0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 1, 0);
      check("rst_up_held_run", 1, 0, 6'd0, 6'd0, 0);
    end
    cyc(1, 1, 0, 0, 0);
    check("rst_mode_with_up", 0, 5, 6'd0, 6'd0, 1);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, 0, 1, 0);
      check("held_no_repeat", 0, 5, 6'd0, 6'd0, (i < 2 || i == 5 || i == 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
